// File: rtl/fft_inverse_butterfly.sv
// Radix-2 inverse butterfly: E = (A+B)/2, O = conj(W)*(A-B)/2, three-stage
// valid/ready pipeline with per-stage hold and round/saturate on the odd term.
module fft_inverse_butterfly #(
  parameter int unsigned twiddle_size = 16,
  parameter int unsigned sample_size  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*sample_size-1:0]   in_real,
  input  logic [2*sample_size-1:0]   in_imag,
  input  logic [twiddle_size-1:0]    twiddle_real,
  input  logic [twiddle_size-1:0]    twiddle_imag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [sample_size-1:0]     even_real,
  output logic [sample_size-1:0]     even_imag,
  output logic [sample_size-1:0]     odd_real,
  output logic [sample_size-1:0]     odd_imag,
  output logic                       sat_flag
);

  localparam int unsigned SW = sample_size;
  localparam int unsigned TW = twiddle_size;
  localparam int unsigned PW = SW + TW;
  localparam int unsigned CW = PW + 1;

  localparam logic signed [SW-1:0] OMAX   = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN   = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [CW-1:0] SAT_HI = CW'(OMAX);
  localparam logic signed [CW-1:0] SAT_LO = CW'(OMIN);
  localparam logic signed [CW-1:0] RND    = CW'(1) << (TW - 2);

  // Pipeline valid bits and stall-aware advance chain
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3      = out_ready | ~v3;
  assign adv2      = adv3 | ~v2;
  assign adv1      = adv2 | ~v1;
  assign in_ready  = adv1;
  assign out_valid = v3;

  // ---------------------------------------------------------------- S1 math
  logic signed [SW-1:0] a_re, a_im, b_re, b_im;
  logic signed [SW:0]   sum_re, sum_im, dif_re, dif_im;

  assign a_re = in_real[SW-1:0];
  assign b_re = in_real[2*SW-1:SW];
  assign a_im = in_imag[SW-1:0];
  assign b_im = in_imag[2*SW-1:SW];

  assign sum_re = {a_re[SW-1], a_re} + {b_re[SW-1], b_re};
  assign sum_im = {a_im[SW-1], a_im} + {b_im[SW-1], b_im};
  assign dif_re = {a_re[SW-1], a_re} - {b_re[SW-1], b_re};
  assign dif_im = {a_im[SW-1], a_im} - {b_im[SW-1], b_im};

  // Floor halving is the arithmetic shift; dropping the LSB gives the same bits.
  logic unused_lsbs;
  assign unused_lsbs = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};

  logic signed [SW-1:0] e1_re, e1_im, d1_re, d1_im;
  logic signed [TW-1:0] w1_re, w1_im;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      e1_re <= '0;
      e1_im <= '0;
      d1_re <= '0;
      d1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        e1_re <= sum_re[SW:1];
        e1_im <= sum_im[SW:1];
        d1_re <= dif_re[SW:1];
        d1_im <= dif_im[SW:1];
        w1_re <= twiddle_real;
        w1_im <= twiddle_imag;
      end
    end
  end

  // ---------------------------------------------------------------- S2 products
  logic signed [SW-1:0] e2_re, e2_im;
  logic signed [PW-1:0] p0, p1, p2, p3;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      e2_re <= '0;
      e2_im <= '0;
      p0    <= '0;
      p1    <= '0;
      p2    <= '0;
      p3    <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        e2_re <= e1_re;
        e2_im <= e1_im;
        p0    <= PW'(d1_re) * PW'(w1_re);
        p1    <= PW'(d1_im) * PW'(w1_im);
        p2    <= PW'(d1_im) * PW'(w1_re);
        p3    <= PW'(d1_re) * PW'(w1_im);
      end
    end
  end

  // ---------------------------------------------------------------- S3 combine
  logic signed [CW-1:0] c_re, c_im, r_re, r_im;

  assign c_re = CW'(p0) + CW'(p1);
  assign c_im = CW'(p2) - CW'(p3);
  assign r_re = (c_re + RND) >>> (TW - 1);
  assign r_im = (c_im + RND) >>> (TW - 1);

  // Returns {clipped, value}
  function automatic logic [SW:0] clip(input logic signed [CW-1:0] x);
    if (x > SAT_HI)      return {1'b1, OMAX};
    else if (x < SAT_LO) return {1'b1, OMIN};
    else                 return {1'b0, x[SW-1:0]};
  endfunction

  logic [SW:0] k_re, k_im;
  assign k_re = clip(r_re);
  assign k_im = clip(r_im);

  always_ff @(posedge clk) begin
    if (reset) begin
      v3        <= 1'b0;
      even_real <= '0;
      even_imag <= '0;
      odd_real  <= '0;
      odd_imag  <= '0;
      sat_flag  <= 1'b0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        even_real <= e2_re;
        even_imag <= e2_im;
        odd_real  <= k_re[SW-1:0];
        odd_imag  <= k_im[SW-1:0];
        sat_flag  <= k_re[SW] | k_im[SW];
      end
    end
  end

endmodule
